// File: rtl/id_stage_bypass.sv
// id_stage_bypass: LA32R decode stage sitting between IF and EX.
// Registers the IF payload, decodes the base integer and branch/jump set,
// resolves read-after-write hazards against in-flight writers and resolves
// branches, issuing exactly one redirect per branch instruction.
// Build option DS_BYPASS_EN: when defined, ready in-flight results are forwarded;
// when undefined, any in-flight writer of a used source register stalls the stage.
// Bus layout, MSB first: {alu_op, load_op, store_op, src1_is_pc, src2_is_imm,
// gr_we, dest[4:0], imm, src1, src2, pc}, ALU_OP_W + 138 bits in total.
module id_stage_bypass #(
    parameter int NBYP     = 3,
    parameter int ALU_OP_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fs_to_ds_valid,
    input  logic [31:0]           fs_pc,
    input  logic [31:0]           fs_inst,
    output logic                  ds_allowin,
    input  logic                  es_allowin,
    output logic                  ds_to_es_valid,
    output logic [ALU_OP_W+137:0] ds_to_es_bus,
    output logic                  br_valid,
    output logic [31:0]           br_target,
    input  logic [NBYP-1:0]       byp_valid,
    input  logic [NBYP*5-1:0]     byp_dest,
    input  logic [NBYP-1:0]       byp_ready,
    input  logic [NBYP*32-1:0]    byp_data,
    input  logic                  rf_we,
    input  logic [4:0]            rf_waddr,
    input  logic [31:0]           rf_wdata
);

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        br_done_q, br_done_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic is_add, is_sub, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
    logic is_slli, is_srli, is_srai, is_addi, is_lu12i, is_ld, is_st;
    logic is_jirl, is_b, is_bl, is_beq, is_bne;
    logic op_3r, op_shift;
    logic src1_used, src2_used;
    logic gr_we, load_op, store_op, src1_is_pc, src2_is_imm;
    logic [4:0]          dest;
    logic [31:0]         imm;
    logic [ALU_OP_W-1:0] alu_op;

    logic [1:0][4:0]  src_addr;
    logic [1:0][31:0] src_val;
    logic [1:0]       src_hit;
    logic [1:0]       src_blk;

    logic        ds_ready_go;
    logic [31:0] src1, src2;
    logic        taken;
    logic [31:0] offs16, offs26;

`ifndef DS_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_data, byp_ready};
`endif

    // Instruction decode: opcode match, operand usage and control fields.
    always_comb begin
        is_add   = inst_q[31:15] == 17'h00020;
        is_sub   = inst_q[31:15] == 17'h00022;
        is_slt   = inst_q[31:15] == 17'h00024;
        is_sltu  = inst_q[31:15] == 17'h00025;
        is_nor   = inst_q[31:15] == 17'h00028;
        is_and   = inst_q[31:15] == 17'h00029;
        is_or    = inst_q[31:15] == 17'h0002a;
        is_xor   = inst_q[31:15] == 17'h0002b;
        is_slli  = inst_q[31:15] == 17'h00081;
        is_srli  = inst_q[31:15] == 17'h00089;
        is_srai  = inst_q[31:15] == 17'h00091;
        is_addi  = inst_q[31:22] == 10'h00a;
        is_lu12i = inst_q[31:25] == 7'h0a;
        is_ld    = inst_q[31:22] == 10'h0a2;
        is_st    = inst_q[31:22] == 10'h0a6;
        is_jirl  = inst_q[31:26] == 6'h13;
        is_b     = inst_q[31:26] == 6'h14;
        is_bl    = inst_q[31:26] == 6'h15;
        is_beq   = inst_q[31:26] == 6'h16;
        is_bne   = inst_q[31:26] == 6'h17;

        op_3r    = is_add | is_sub | is_slt | is_sltu | is_nor | is_and | is_or | is_xor;
        op_shift = is_slli | is_srli | is_srai;

        src1_used   = op_3r | op_shift | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
        src2_used   = op_3r | is_st | is_beq | is_bne;
        gr_we       = op_3r | op_shift | is_addi | is_lu12i | is_ld | is_jirl | is_bl;
        load_op     = is_ld;
        store_op    = is_st;
        src1_is_pc  = is_jirl | is_bl;
        src2_is_imm = op_shift | is_addi | is_lu12i | is_ld | is_st | is_jirl | is_bl;
        dest        = is_bl ? 5'd1 : inst_q[4:0];

        if (is_jirl || is_bl) begin
            imm = 32'd4;
        end else if (is_lu12i) begin
            imm = {inst_q[24:5], 12'b0};
        end else if (op_shift) begin
            imm = {27'b0, inst_q[14:10]};
        end else begin
            imm = {{20{inst_q[21]}}, inst_q[21:10]};
        end

        alu_op     = '0;
        alu_op[0]  = is_add | is_addi | is_ld | is_st | is_jirl | is_bl;
        alu_op[1]  = is_sub;
        alu_op[2]  = is_slt;
        alu_op[3]  = is_sltu;
        alu_op[4]  = is_and;
        alu_op[5]  = is_nor;
        alu_op[6]  = is_or;
        alu_op[7]  = is_xor;
        alu_op[8]  = is_slli;
        alu_op[9]  = is_srli;
        alu_op[10] = is_srai;
        alu_op[11] = is_lu12i;

        src_addr[0] = inst_q[9:5];
        src_addr[1] = op_3r ? inst_q[14:10] : inst_q[4:0];
    end

    // Operand select: youngest matching in-flight writer, then WB write-through, then regfile.
    always_comb begin
        src_hit = '0;
        src_blk = '0;
        src_val = '0;
        for (int k = 0; k < 2; k++) begin
            if (rf_we && rf_waddr == src_addr[k]) begin
                src_val[k] = rf_wdata;
            end else begin
                src_val[k] = rf_q[src_addr[k]];
            end
            if (src_addr[k] == 5'd0) begin
                src_val[k] = '0;
            end
            for (int i = 0; i < NBYP; i++) begin
                if (!src_hit[k] && src_addr[k] != 5'd0 && byp_valid[i] &&
                    byp_dest[i*5 +: 5] == src_addr[k]) begin
                    src_hit[k] = 1'b1;
`ifdef DS_BYPASS_EN
                    src_blk[k] = !byp_ready[i];
                    src_val[k] = byp_data[i*32 +: 32];
`else
                    src_blk[k] = 1'b1;
`endif
                end
            end
        end
    end

    // Handshake, final operands, branch resolution and the outgoing bus.
    always_comb begin
        ds_ready_go    = !((src1_used & src_blk[0]) | (src2_used & src_blk[1]));
        ds_allowin     = !ds_valid_q | (ds_ready_go & es_allowin);
        ds_to_es_valid = ds_valid_q & ds_ready_go;

        src1 = src1_used ? src_val[0] : 32'd0;
        src2 = src2_used ? src_val[1] : imm;

        taken = (is_beq & (src_val[0] == src_val[1])) |
                (is_bne & (src_val[0] != src_val[1])) |
                is_jirl | is_b | is_bl;
        br_valid = ds_valid_q & ds_ready_go & taken & !br_done_q;

        offs16 = {{14{inst_q[25]}}, inst_q[25:10], 2'b0};
        offs26 = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b0};
        if (is_jirl) begin
            br_target = src_val[0] + offs16;
        end else if (is_b || is_bl) begin
            br_target = pc_q + offs26;
        end else begin
            br_target = pc_q + offs16;
        end

        ds_to_es_bus = {alu_op, load_op, store_op, src1_is_pc, src2_is_imm, gr_we,
                        dest, imm, src1, src2, pc_q};
    end

    // Next-state for the payload, valid bit and redirect-issued flag.
    always_comb begin
        ds_valid_d = ds_valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        br_done_d  = br_done_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end
        if (fs_to_ds_valid && ds_allowin) begin
            pc_d   = fs_pc;
            inst_d = fs_inst;
        end
        if (ds_to_es_valid && es_allowin) begin
            br_done_d = 1'b0;
        end else if (br_valid && !es_allowin) begin
            br_done_d = 1'b1;
        end
        if (reset) begin
            ds_valid_d = 1'b0;
            br_done_d  = 1'b0;
        end
    end

    // Regfile next-state: WB write, r0 stays hard-wired to zero on read.
    always_comb begin
        rf_d = rf_q;
        if (rf_we && rf_waddr != 5'd0) begin
            rf_d[rf_waddr] = rf_wdata;
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        ds_valid_q <= ds_valid_d;
        pc_q       <= pc_d;
        inst_q     <= inst_d;
        br_done_q  <= br_done_d;
        rf_q       <= rf_d;
    end

endmodule
